// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures a request vector and emits the index
// of each set bit, one per handshake, lowest-first or highest-first.
module seq_priority_encoder #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic [W:0]   hit_count,
  output logic         err_zero
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] pend_clr;

  function automatic logic [W-1:0] sel_idx(input logic [N-1:0] v);
    sel_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++)
        if (v[i]) sel_idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (v[i]) sel_idx = W'(i);
    end
  endfunction

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    popcnt = '0;
    for (int i = 0; i < N; i++)
      popcnt = popcnt + {{W{1'b0}}, v[i]};
  endfunction

  function automatic logic single_bit(input logic [N-1:0] v);
    single_bit = (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Pending vector with the currently presented bit removed.
  always_comb begin
    pend_clr = pending & ~(ONE << out_idx);
  end

  // flush gates acceptance combinationally so an abort cycle never loads.
  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      hit_count <= '0;
      err_zero  <= 1'b0;
    end else begin
      err_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            if (in_vec != '0) begin
              pending   <= in_vec;
              hit_count <= popcnt(in_vec);
              out_idx   <= sel_idx(in_vec);
              out_last  <= single_bit(in_vec);
              state     <= DRAIN;
            end else begin
              err_zero <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (flush || (out_ready && out_last)) begin
            pending  <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            state    <= IDLE;
          end else if (out_ready) begin
            pending  <= pend_clr;
            out_idx  <= sel_idx(pend_clr);
            out_last <= single_bit(pend_clr);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
